// File: rtl/cube_pkg.sv
// Shared types and helpers for the LED cube animation generator.
// Holds cube geometry, the animation mode and FSM state enums, and the BOX edge test.
package cube_pkg;

  localparam int LAYER_W = 64;
  localparam int CUBE_N  = 8;

  typedef enum logic [1:0] {
    MODE_SWEEP_Z = 2'd0,
    MODE_SWEEP_X = 2'd1,
    MODE_BOX     = 2'd2,
    MODE_RAIN    = 2'd3
  } cube_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RENDER = 2'd1,
    PEND   = 2'd2
  } cube_state_e;

  // A voxel lies on the box wireframe when it is inside [lo, hi] on every axis
  // and sits on a face in at least two of them.
  function automatic logic box_bit(input logic [2:0] x, input logic [2:0] y,
                                   input logic [2:0] z, input logic [1:0] step);
    logic [2:0] lo;
    logic [2:0] hi;
    logic       in_x;
    logic       in_y;
    logic       in_z;
    logic [1:0] edges;
    lo    = 3'd3 - {1'b0, step};
    hi    = 3'd4 + {1'b0, step};
    in_x  = (x >= lo) && (x <= hi);
    in_y  = (y >= lo) && (y <= hi);
    in_z  = (z >= lo) && (z <= hi);
    edges = 2'((x == lo) || (x == hi)) + 2'((y == lo) || (y == hi)) + 2'((z == lo) || (z == hi));
    return in_x && in_y && in_z && (edges >= 2'd2);
  endfunction

endpackage

// File: rtl/cube_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the raindrop position source.
// Only present when CUBE_ANIM_RAIN_EN is defined.
`ifdef CUBE_ANIM_RAIN_EN
module cube_lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_reg;
  logic        fb;

  assign fb = q_reg[0] ^ q_reg[2] ^ q_reg[3] ^ q_reg[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= seed;
    end else if (en) begin
      q_reg <= {fb, q_reg[15:1]};
    end
  end

  assign q = q_reg;

endmodule
`endif

// File: rtl/cube_anim_gen.sv
// Renders 8x8x8 cube animation frames into a back buffer and presents them on the scanner's frame_ack.
// Define CUBE_ANIM_RAIN_EN for the LFSR-driven RAIN mode; otherwise mode 3 is an all-ones lamp test.
module cube_anim_gen
  import cube_pkg::*;
#(
  parameter int          TICK_DIV = 25_000_000,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        pause,
  input  logic        next_pulse,
  input  logic        frame_ack,
  output logic [63:0] layer_1,
  output logic [63:0] layer_2,
  output logic [63:0] layer_3,
  output logic [63:0] layer_4,
  output logic [63:0] layer_5,
  output logic [63:0] layer_6,
  output logic [63:0] layer_7,
  output logic [63:0] layer_8,
  output logic        frame_valid,
  output logic        overrun
);

  localparam int               CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  cube_state_e        state_reg;
  cube_state_e        state_next;
  cube_mode_e         mode_in;
  cube_mode_e         cur_mode_reg;
  cube_mode_e         last_mode_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2:0]         z_reg;
  logic [2:0]         step_reg;
  logic [2:0]         step_next;
  logic               frame_valid_reg;
  logic               overrun_reg;
  logic               tick;
  logic               req;
  logic               start;
  logic               last_layer;
  logic               present;
  logic               drop;
  logic [7:0]         sweep_row;
  logic [LAYER_W-1:0] box_word;
  logic [LAYER_W-1:0] render_word;
  logic [LAYER_W-1:0] back_reg  [CUBE_N];
  logic [LAYER_W-1:0] front_reg [CUBE_N];

  assign mode_in = cube_mode_e'(mode);
  assign tick    = (cnt_reg == TICK_LAST) & ~pause;
  assign req     = tick | next_pulse;

`ifdef CUBE_ANIM_RAIN_EN
  logic [15:0] lfsr_q;
  logic [9:0]  unused_lfsr_hi;

  cube_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (last_layer),
    .seed (SEED),
    .q    (lfsr_q)
  );

  assign unused_lfsr_hi = lfsr_q[15:6];
`else
  logic [15:0] unused_seed;
  assign unused_seed = SEED;
`endif

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    last_layer = 1'b0;
    present    = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          start      = 1'b1;
          state_next = RENDER;
        end
      end
      RENDER: begin
        drop = req;
        if (z_reg == 3'd7) begin
          last_layer = 1'b1;
          state_next = PEND;
        end
      end
      PEND: begin
        drop = req;
        if (frame_ack) begin
          present    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // BOX cycles through four sizes; every other mode sweeps all eight positions.
  assign step_next = (cur_mode_reg == MODE_BOX) ? {1'b0, step_reg[1:0] + 2'd1} : step_reg + 3'd1;
  assign sweep_row = 8'd1 << step_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LAYER_W; gi++) begin : g_box
      assign box_word[gi] = box_bit(3'(gi % CUBE_N), 3'(gi / CUBE_N), z_reg, step_reg[1:0]);
    end
  endgenerate

  always_comb begin
    render_word = '0;
    case (cur_mode_reg)
      MODE_SWEEP_Z: render_word = {LAYER_W{z_reg == step_reg}};
      MODE_SWEEP_X: render_word = {CUBE_N{sweep_row}};
      MODE_BOX:     render_word = box_word;
      MODE_RAIN: begin
`ifdef CUBE_ANIM_RAIN_EN
        // Drops fall one layer per frame; a fresh drop enters at the top.
        render_word = (z_reg == 3'd7) ? (LAYER_W'(1) << lfsr_q[5:0]) : front_reg[z_reg + 3'd1];
`else
        render_word = '1;
`endif
      end
      default: render_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      z_reg           <= '0;
      step_reg        <= '0;
      cur_mode_reg    <= MODE_SWEEP_Z;
      last_mode_reg   <= MODE_SWEEP_Z;
      frame_valid_reg <= 1'b0;
      overrun_reg     <= 1'b0;
      for (int k = 0; k < CUBE_N; k++) begin
        front_reg[k] <= '0;
      end
    end else begin
      state_reg <= state_next;
      cnt_reg   <= (cnt_reg == TICK_LAST) ? '0 : cnt_reg + CNT_W'(1);
      if (start) begin
        cur_mode_reg  <= mode_in;
        last_mode_reg <= mode_in;
        z_reg         <= '0;
        if (mode_in != last_mode_reg) begin
          step_reg <= '0;
        end
      end
      if (state_reg == RENDER) begin
        z_reg <= z_reg + 3'd1;
      end
      if (last_layer) begin
        step_reg        <= step_next;
        frame_valid_reg <= 1'b1;
      end
      if (present) begin
        for (int k = 0; k < CUBE_N; k++) begin
          front_reg[k] <= back_reg[k];
        end
        frame_valid_reg <= 1'b0;
      end
      if (drop) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_reg == RENDER) begin
      back_reg[z_reg] <= render_word;
    end
  end

  assign layer_1     = front_reg[0];
  assign layer_2     = front_reg[1];
  assign layer_3     = front_reg[2];
  assign layer_4     = front_reg[3];
  assign layer_5     = front_reg[4];
  assign layer_6     = front_reg[5];
  assign layer_7     = front_reg[6];
  assign layer_8     = front_reg[7];
  assign frame_valid = frame_valid_reg;
  assign overrun     = overrun_reg;

endmodule
